// File: rtl/tdc_ctrl_pkg.sv
// Shared types and constants for the TDC start/stop pair sequencer.
package tdc_ctrl_pkg;

  localparam int TS_W_DEF = 37;
  localparam int CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  // Pair sequencer states; IDLE is the only non-busy state.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_STOP = 3'd1,
    SEND_A    = 3'd2,
    SEND_B    = 3'd3,
    HOLD      = 3'd4
  } state_t;

  // Number of strobes present in one cycle (0, 1 or 2), used for lost-event counting.
  function automatic logic [1:0] evt_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating event counter: adds 0, 1 or 2 per cycle, sticks at all-ones,
// and a clear wins over any increment in the same cycle.
module sat_cnt
  import tdc_ctrl_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic [1:0]   inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W:0]   sum;

  // Next count: clear first, otherwise add with saturation on carry-out.
  always_comb begin
    sum   = {1'b0, cnt_q} + (W+1)'(inc_i);
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (sum[W]) begin
      cnt_d = '1;
    end else begin
      cnt_d = sum[W-1:0];
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/tdc_pair_ctrl.sv
// TDC pair sequencer: pairs a start timestamp with the next stop timestamp,
// enforces a stop timeout, emits the pair as two back-to-back beats and then
// holds off so the downstream subtractor can finish. Counts good pairs and
// lost/orphan events.
//
// Interface semantics: start_valid/stop_valid are one-cycle strobes with the
// timestamp valid in the same cycle; there is no backpressure in either
// direction. out_dval is a one-cycle beat strobe qualifying out_mlt; the
// downstream must accept every beat. out_mlt holds its value between beats.
module tdc_pair_ctrl
  import tdc_ctrl_pkg::*;
#(
  parameter int TS_W    = TS_W_DEF,
  parameter int TIMEOUT = 4096,
  parameter int HOLDOFF = 2,
  parameter int GATE_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             gate,
  input  logic             start_valid,
  input  logic [TS_W-1:0]  start_ts,
  input  logic             stop_valid,
  input  logic [TS_W-1:0]  stop_ts,
  input  logic             clr_cnt,
  output logic             out_dval,
  output logic [TS_W-1:0]  out_mlt,
  output logic             busy,
  output logic             timeout_p,
  output logic [CNT_W-1:0] pair_cnt,
  output logic [CNT_W-1:0] lost_cnt,
  output state_t           dbg_state
);

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] HOLD_LOAD  = 16'(HOLDOFF - 1);

  state_t          state_q, state_d;
  logic [TS_W-1:0] start_q, start_d;
  logic [TS_W-1:0] stop_q, stop_d;
  logic [15:0]     timer_q, timer_d;
  logic [15:0]     hold_q, hold_d;
  logic            dval_q, dval_d;
  logic [TS_W-1:0] mlt_q, mlt_d;
  logic            busy_q, busy_d;
  logic            tmo_q, tmo_d;

  logic            start_ok;
  logic            expire;
  logic [1:0]      lost_inc;
  logic [1:0]      pair_inc;

  // A start qualifies only while enabled and, when gating is on, inside the gate.
  assign start_ok = start_valid && enable && (gate || (GATE_EN == 0));

  // State and datapath registers; reset abandons any pair in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      start_q <= '0;
      stop_q  <= '0;
      timer_q <= '0;
      hold_q  <= '0;
      dval_q  <= 1'b0;
      mlt_q   <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      timer_q <= timer_d;
      hold_q  <= hold_d;
      dval_q  <= dval_d;
      mlt_q   <= mlt_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state logic: pairing, re-trigger, abort, timeout and hold-off sequencing.
  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    stop_d   = stop_q;
    timer_d  = timer_q;
    hold_d   = hold_q;
    lost_inc = 2'd0;
    pair_inc = 2'd0;
    expire   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          start_d = start_ts;
          timer_d = '0;
          state_d = WAIT_STOP;
        end
        // A stop with no pending start has nothing to pair with.
        if (stop_valid) begin
          lost_inc = 2'd1;
        end
      end
      WAIT_STOP: begin
        if (stop_valid) begin
          stop_d   = stop_ts;
          state_d  = SEND_A;
          lost_inc = {1'b0, start_valid};
        end else if (start_ok) begin
          start_d  = start_ts;
          timer_d  = '0;
          lost_inc = 2'd1;
        end else if (!enable) begin
          state_d  = IDLE;
          lost_inc = 2'd1;
        end else if (timer_q == TIMER_LAST) begin
          expire   = 1'b1;
          state_d  = IDLE;
          lost_inc = 2'd1;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      SEND_A: begin
        lost_inc = evt_count(start_valid, stop_valid);
        state_d  = SEND_B;
      end
      SEND_B: begin
        lost_inc = evt_count(start_valid, stop_valid);
        pair_inc = 2'd1;
        hold_d   = HOLD_LOAD;
        state_d  = HOLD;
      end
      HOLD: begin
        lost_inc = evt_count(start_valid, stop_valid);
        if (hold_q == 16'd0) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q - 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: registered beats follow the state being entered, so a stop
  // at edge N produces the start beat after N and the stop beat after N+1.
  always_comb begin
    dval_d = 1'b0;
    mlt_d  = mlt_q;
    busy_d = (state_d != IDLE);
    tmo_d  = expire;
    if (state_d == SEND_A) begin
      dval_d = 1'b1;
      mlt_d  = start_q;
    end else if (state_d == SEND_B) begin
      dval_d = 1'b1;
      mlt_d  = stop_q;
    end
  end

  sat_cnt #(.W(CNT_W)) u_pair_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr_cnt),
    .inc_i (pair_inc),
    .cnt_o (pair_cnt)
  );

  sat_cnt #(.W(CNT_W)) u_lost_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr_cnt),
    .inc_i (lost_inc),
    .cnt_o (lost_cnt)
  );

  assign out_dval  = dval_q;
  assign out_mlt   = mlt_q;
  assign busy      = busy_q;
  assign timeout_p = tmo_q;
  assign dbg_state = state_q;

endmodule
